avr_cpu_register_file: RTL
==========================

# avr_cpu_register_file

Parametrised general-purpose register file for the AVR CPU core. It provides:
- two byte read ports (Rr, Rd) and one byte write port;
- a 16-bit register-pair read/write path for MOVW/ADIW/SBIW;
- an X/Y/Z pointer unit with post-increment and pre-decrement;
- optional write-to-read bypass;
- a handshaked debug read port.

It sits between the decoder and the ALU/LSU, and it is the only owner of register state.

## Interface
- DATA_W, 8, register width in bits
- NUM_REGS, 32, register count; power of two, ≥ 8
- ADDR_W, $clog2(NUM_REGS), register address width
- BYPASS, 1, 1 = reads return same-cycle write data; 0 = reads return the pre-edge value

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- r_addr  in  ADDR_W  Rr read address
- d_addr  in  ADDR_W  Rd read/write address
- r_out  out  DATA_W  Rr read data
- d_out  out  DATA_W  Rd read data
- d_we  in  1  byte write enable for d_addr
- d_in  in  DATA_W  byte write data
- w_we  in  1  pair write enable for {d_addr|1, d_addr&~1}
- w_in  in  2*DATA_W  pair write data; high byte → odd register
- w_out  out  2*DATA_W  pair read at d_addr&~1
- ptr_sel  in  2  0 = none, 1 = X, 2 = Y, 3 = Z
- ptr_op  in  2  0 = hold, 1 = post-inc, 2 = pre-dec, 3 = reserved (treated as hold)
- ptr_out  out  2*DATA_W  effective address
- dbg_req  in  1  debug read request, level
- dbg_addr  in  ADDR_W  debug register address
- dbg_ack  out  1  debug data valid, one-cycle pulse
- dbg_data  out  DATA_W  registered debug data

## Operation
- Pointer pairs:
  - X = NUM_REGS-6/-5, Y = NUM_REGS-4/-3, Z = NUM_REGS-2/-1, each as low/high.
  - For NUM_REGS = 32 this gives r26..r31.
- Reads (r_out, d_out, w_out) are combinational.
- Bypass:
  - With BYPASS = 1, a read of a byte written this cycle returns the new value, using the same write priority as below.
  - With BYPASS = 0, the read returns the stored value.
- Byte write: on a rising edge with d_we = 1, register[d_addr] ← d_in.
- Pair write: on a rising edge with w_we = 1, the even register ← w_in[DATA_W-1:0] and the odd register ← w_in[2*DATA_W-1:DATA_W].
- Pointer unit: with ptr_sel ≠ 0, let P be the selected pair value.
  - Post-increment: ptr_out = P, and the pair ← P+1.
  - Pre-decrement: ptr_out = P-1, and the pair ← P-1.
  - Hold: ptr_out = P, no update.
  - Arithmetic is modulo 2^(2*DATA_W): 0xFFFF+1 → 0x0000 and 0x0000-1 → 0xFFFF when DATA_W = 8.
- ptr_sel = 0 forces ptr_out = 0 and no pointer update.
- Write priority per byte when several writers hit the same cycle: d_we > w_we > pointer update.
  - Example: LD r26, X+ with d_we on r26 stores the load data in r26, while r27 takes the pointer-update high byte.
- Debug FSM:
  - IDLE → ACK when dbg_req = 1; dbg_data is captured from the stored (pre-edge) register[dbg_addr] at that edge.
  - ACK drives dbg_ack = 1 for exactly one cycle, then → WAIT.
  - WAIT → IDLE when dbg_req = 0.
  - Debug reads never stall CPU accesses.

## Timing
- Reset (rst = 0, asynchronous): all registers are 0, the FSM is in IDLE, dbg_ack = 0 and dbg_data = 0, all immediately.
  - Combinational outputs therefore read 0 while in reset.
- Writes and pointer updates become visible in stored state one edge after they are presented.
- Debug latency: request edge → dbg_ack high in the following cycle.
  - A request still high in WAIT is not re-serviced; the requester must drop dbg_req for at least one cycle.
- Reset asserted mid-handshake aborts it: dbg_ack is forced to 0 and the FSM returns to IDLE.
- On the first edge after rst releases, writes take effect normally.

## Structure
- Shared package avr_cpu_pkg holds:
  - PTR_NONE/X/Y/Z and PTR_HOLD/POSTINC/PREDEC encodings;
  - the debug FSM state constants.
- Sub-module avr_cpu_ptr_unit: a combinational block producing pair-select, next-pointer and ptr_out from ptr_sel, ptr_op and the pair value.

## Test plan
- Reset check: write 0xA5 to r5, then assert rst low asynchronously between edges → r_out (r_addr = 5) reads 0x00 immediately, and dbg_ack = 0.
- Pair write: w_we with d_addr = 24 and w_in = 0x1234 → r24 = 0x34, r25 = 0x12, and w_out (d_addr = 25) = 0x1234 on the next cycle.
- Pointer wrap:
  - Z = 0xFFFF, post-increment → ptr_out = 0xFFFF and Z becomes 0x0000.
  - X = 0x0000, pre-decrement → ptr_out = 0xFFFF and X becomes 0xFFFF.
- Write conflict: X = 0x0100, post-increment, and d_we on r26 with 0x77 in the same cycle → r26 = 0x77, r27 = 0x01.
- Bypass: d_we r3 ← 0x5A while r_addr = 3.
  - BYPASS = 1 → r_out = 0x5A in the same cycle.
  - BYPASS = 0 → r_out shows the old value, then 0x5A next cycle.
- Debug handshake: dbg_req held high for 4 cycles, dbg_addr = 10, r10 = 0xC3 → exactly one dbg_ack pulse, in the cycle after the first request edge, with dbg_data = 0xC3. A second request is serviced only after dbg_req drops.

Source files
------------

// File: rtl/avr_cpu_pkg.sv
// Shared encodings for the AVR CPU register file: pointer select/op codes
// and the debug read handshake states.
package avr_cpu_pkg;

  localparam logic [1:0] PTR_NONE = 2'd0;
  localparam logic [1:0] PTR_X    = 2'd1;
  localparam logic [1:0] PTR_Y    = 2'd2;
  localparam logic [1:0] PTR_Z    = 2'd3;

  localparam logic [1:0] PTR_HOLD    = 2'd0;
  localparam logic [1:0] PTR_POSTINC = 2'd1;
  localparam logic [1:0] PTR_PREDEC  = 2'd2;

  typedef enum logic [1:0] {
    DBG_IDLE = 2'd0,
    DBG_ACK  = 2'd1,
    DBG_WAIT = 2'd2
  } dbg_state_t;

endpackage

// File: rtl/avr_cpu_ptr_unit.sv
// X/Y/Z pointer arithmetic: picks the low register of the selected pair and
// computes the effective address and the written-back pointer value.
module avr_cpu_ptr_unit
  import avr_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic [1:0]          ptr_sel_i,
  input  logic [1:0]          ptr_op_i,
  input  logic [2*DATA_W-1:0] pair_i,
  output logic [ADDR_W-1:0]   lo_idx_o,
  output logic                upd_o,
  output logic [2*DATA_W-1:0] next_o,
  output logic [2*DATA_W-1:0] ptr_o
);

  localparam int PW = 2 * DATA_W;

  always_comb begin
    lo_idx_o = '0;
    case (ptr_sel_i)
      PTR_X:   lo_idx_o = ADDR_W'(NUM_REGS - 6);
      PTR_Y:   lo_idx_o = ADDR_W'(NUM_REGS - 4);
      PTR_Z:   lo_idx_o = ADDR_W'(NUM_REGS - 2);
      default: lo_idx_o = '0;
    endcase
  end

  always_comb begin
    upd_o  = 1'b0;
    next_o = pair_i;
    ptr_o  = '0;
    if (ptr_sel_i != PTR_NONE) begin
      ptr_o = pair_i;
      case (ptr_op_i)
        PTR_POSTINC: begin
          next_o = pair_i + PW'(1);
          upd_o  = 1'b1;
        end
        PTR_PREDEC: begin
          next_o = pair_i - PW'(1);
          ptr_o  = pair_i - PW'(1);
          upd_o  = 1'b1;
        end
        default: upd_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/avr_cpu_register_file.sv
// AVR general-purpose register file: two byte read ports, byte/pair write,
// X/Y/Z pointer update, optional write bypass and a debug read handshake.
module avr_cpu_register_file
  import avr_cpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   r_addr,
  input  logic [ADDR_W-1:0]   d_addr,
  output logic [DATA_W-1:0]   r_out,
  output logic [DATA_W-1:0]   d_out,
  input  logic                d_we,
  input  logic [DATA_W-1:0]   d_in,
  input  logic                w_we,
  input  logic [2*DATA_W-1:0] w_in,
  output logic [2*DATA_W-1:0] w_out,
  input  logic [1:0]          ptr_sel,
  input  logic [1:0]          ptr_op,
  output logic [2*DATA_W-1:0] ptr_out,
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic                dbg_ack,
  output logic [DATA_W-1:0]   dbg_data
);

  logic [DATA_W-1:0]   regs_q  [NUM_REGS];
  logic [DATA_W-1:0]   regs_d  [NUM_REGS];
  logic [DATA_W-1:0]   rd_view [NUM_REGS];

  logic [ADDR_W-1:0]   ptr_lo, ptr_hi, w_lo, w_hi;
  logic                ptr_upd;
  logic [2*DATA_W-1:0] ptr_next, ptr_eff, ptr_pair;

  assign w_lo     = {d_addr[ADDR_W-1:1], 1'b0};
  assign w_hi     = {d_addr[ADDR_W-1:1], 1'b1};
  assign ptr_hi   = ptr_lo | ADDR_W'(1);
  // Pointer arithmetic always uses stored state, which keeps the bypass path loop-free.
  assign ptr_pair = {regs_q[ptr_hi], regs_q[ptr_lo]};

  avr_cpu_ptr_unit #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_ptr (
    .ptr_sel_i (ptr_sel),
    .ptr_op_i  (ptr_op),
    .pair_i    (ptr_pair),
    .lo_idx_o  (ptr_lo),
    .upd_o     (ptr_upd),
    .next_o    (ptr_next),
    .ptr_o     (ptr_eff)
  );

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic [DATA_W-1:0] r_q, r_d;

      // Later assignments win: d_we over w_we over the pointer update.
      always_comb begin
        r_d = r_q;
        if (ptr_upd && ptr_lo == IDX) r_d = ptr_next[DATA_W-1:0];
        if (ptr_upd && ptr_hi == IDX) r_d = ptr_next[2*DATA_W-1:DATA_W];
        if (w_we && w_lo == IDX)      r_d = w_in[DATA_W-1:0];
        if (w_we && w_hi == IDX)      r_d = w_in[2*DATA_W-1:DATA_W];
        if (d_we && d_addr == IDX)    r_d = d_in;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= '0;
        else      r_q <= r_d;
      end

      assign regs_q[gi]  = r_q;
      assign regs_d[gi]  = r_d;
      assign rd_view[gi] = !rst ? '0 : (BYPASS ? r_d : r_q);
    end
  endgenerate

  assign r_out   = rd_view[r_addr];
  assign d_out   = rd_view[d_addr];
  assign w_out   = {rd_view[w_hi], rd_view[w_lo]};
  assign ptr_out = rst ? ptr_eff : '0;

  dbg_state_t        dbg_state_q, dbg_state_d;
  logic [DATA_W-1:0] dbg_data_q, dbg_data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dbg_state_q <= DBG_IDLE;
      dbg_data_q  <= '0;
    end else begin
      dbg_state_q <= dbg_state_d;
      dbg_data_q  <= dbg_data_d;
    end
  end

  always_comb begin
    dbg_state_d = dbg_state_q;
    dbg_data_d  = dbg_data_q;
    case (dbg_state_q)
      DBG_IDLE: if (dbg_req) begin
        dbg_state_d = DBG_ACK;
        dbg_data_d  = regs_q[dbg_addr];
      end
      DBG_ACK:  dbg_state_d = DBG_WAIT;
      DBG_WAIT: if (!dbg_req) dbg_state_d = DBG_IDLE;
      default:  dbg_state_d = DBG_IDLE;
    endcase
  end

  assign dbg_ack  = (dbg_state_q == DBG_ACK);
  assign dbg_data = dbg_data_q;

endmodule
